i2s_clk_div: RTL and testbench



---
 rtl/i2s_pkg.sv | 11 +
 rtl/i2s_clk_div.sv | 42 ++++
 tb/tb_i2s_clk_div.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S constants: default divider ratios and the lrck channel encoding.
package i2s_pkg;

    localparam int unsigned SCKI_LOG2_DEF = 2;
    localparam int unsigned BCK_LOG2_DEF  = 4;
    localparam int unsigned LRCK_LOG2_DEF = 10;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_clk_div.sv
// Free-running divider producing scki, bck and lrck from mck as taps of one counter.
// All three outputs are flop bits and should be constrained as generated clocks of mck.
module i2s_clk_div
    import i2s_pkg::*;
#(
    parameter int unsigned SCKI_LOG2 = SCKI_LOG2_DEF,
    parameter int unsigned BCK_LOG2  = BCK_LOG2_DEF,
    parameter int unsigned LRCK_LOG2 = LRCK_LOG2_DEF
) (
    input  logic mck,
    input  logic reset,
    output logic scki,
    output logic bck,
    output logic lrck
);

    if (!(SCKI_LOG2 >= 1 && SCKI_LOG2 < BCK_LOG2 && BCK_LOG2 < LRCK_LOG2)) begin : g_bad_params
        $error("i2s_clk_div: need 1 <= SCKI_LOG2 < BCK_LOG2 < LRCK_LOG2");
    end

    logic [LRCK_LOG2-1:0] count_q;
    logic [LRCK_LOG2-1:0] count_d;

    always_comb begin
        count_d = count_q + {{(LRCK_LOG2-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge mck or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Taps are the MSB of each power-of-two sub-count, so every output edge
    // lands on a falling edge of the next-faster clock.
    assign scki = count_q[SCKI_LOG2-1];
    assign bck  = count_q[BCK_LOG2-1];
    assign lrck = count_q[LRCK_LOG2-1];

endmodule

// File: tb/tb_i2s_clk_div.sv
// Self-checking bench for i2s_clk_div: default and reduced-ratio instances.
module tb_i2s_clk_div;
    import i2s_pkg::*;

    logic mck = 1'b0;
    logic reset = 1'b0;
    logic scki, bck, lrck;
    logic v_scki, v_bck, v_lrck;

    int checks = 0;
    int failures = 0;

    i2s_clk_div u_dut (
        .mck  (mck),
        .reset(reset),
        .scki (scki),
        .bck  (bck),
        .lrck (lrck)
    );

    i2s_clk_div #(
        .SCKI_LOG2(1),
        .BCK_LOG2 (3),
        .LRCK_LOG2(8)
    ) u_var (
        .mck  (mck),
        .reset(reset),
        .scki (v_scki),
        .bck  (v_bck),
        .lrck (v_lrck)
    );

    always #5 mck = ~mck;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: number of mck rising edges seen since the last reset release.
    int unsigned n;
    always @(posedge mck or negedge reset) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    // A clock of period P is high for the second half of each P-edge window.
    function automatic logic half(input int unsigned edges, input int unsigned p);
        return (edges % p) >= (p / 2);
    endfunction

    always @(negedge mck) begin
        check("model_scki",   scki,   half(n, 4));
        check("model_bck",    bck,    half(n, 16));
        check("model_lrck",   lrck,   half(n, 1024));
        check("model_v_scki", v_scki, half(n, 2));
        check("model_v_bck",  v_bck,  half(n, 8));
        check("model_v_lrck", v_lrck, half(n, 256));
    end

    // Alignment and edge counting, sampled just after each rising mck edge.
    logic p_scki = 0, p_bck = 0, p_lrck = 0, pv_scki = 0, pv_bck = 0, pv_lrck = 0;
    int scki_rises = 0, bck_rises = 0, lrck_rises = 0;
    int bck_per_frame = 0, v_bck_per_frame = 0;
    int v_lrck_rises = 0;
    bit counting = 0;

    always @(posedge mck) begin
        #1;
        if (reset) begin
            if (lrck != p_lrck) check("align_lrck_bck_fall", (p_bck && !bck), 1'b1);
            if (bck != p_bck)   check("align_bck_scki_fall", (p_scki && !scki), 1'b1);
            if (v_lrck != pv_lrck) check("v_align_lrck_bck_fall", (pv_bck && !v_bck), 1'b1);
            if (v_bck != pv_bck)   check("v_align_bck_scki_fall", (pv_scki && !v_scki), 1'b1);
            if (counting) begin
                if (scki && !p_scki) scki_rises++;
                if (bck && !p_bck)   bck_rises++;
                if (lrck && !p_lrck) lrck_rises++;
            end
            if (bck && !p_bck) bck_per_frame++;
            if (v_bck && !pv_bck) v_bck_per_frame++;
            if (lrck && !p_lrck) begin
                // The first rise after release follows only the left half-frame.
                if (n > 1024) check_int("bck_per_lrck", bck_per_frame, 64);
                bck_per_frame = 0;
            end
            if (v_lrck && !pv_lrck) begin
                v_lrck_rises++;
                if (n > 256) check_int("v_bck_per_lrck", v_bck_per_frame, 32);
                v_bck_per_frame = 0;
            end
        end else begin
            bck_per_frame = 0;
            v_bck_per_frame = 0;
        end
        p_scki = scki; p_bck = bck; p_lrck = lrck;
        pv_scki = v_scki; pv_bck = v_bck; pv_lrck = v_lrck;
    end

    task automatic wait_edges(input int k);
        repeat (k) @(posedge mck);
        #2;
    endtask

    task automatic release_reset();
        @(negedge mck);
        #2;
        reset = 1'b1;
    endtask

    // Pulse reset for two mck cycles once the frame position reaches pos.
    task automatic mid_reset(input int unsigned pos, input logic exp_lrck);
        int guard = 0;
        while ((n % 1024) != pos && guard < 1100) begin
            @(posedge mck);
            #2;
            guard++;
        end
        check_int("mid_reset_found_pos", int'(n % 1024), int'(pos));
        check("mid_reset_lrck_before", lrck, exp_lrck);
        #1;
        reset = 1'b0;
        #1;
        check("async_scki", scki, 1'b0);
        check("async_bck",  bck,  1'b0);
        check("async_lrck", lrck, 1'b0);
        wait_edges(2);
        check("hold_scki", scki, 1'b0);
        check("hold_lrck", lrck, 1'b0);
        release_reset();
        wait_edges(511);
        check("restart_lrck_511", lrck, LRCK_LEFT);
        wait_edges(1);
        check("restart_lrck_512", lrck, LRCK_RIGHT);
    endtask

    initial begin
        wait_edges(3);
        check("reset_scki", scki, 1'b0);
        check("reset_bck",  bck,  1'b0);
        check("reset_lrck", lrck, 1'b0);
        check("reset_v_scki", v_scki, 1'b0);

        release_reset();
        counting = 1;
        wait_edges(1);
        check("scki_edge1",   scki,   1'b0);
        check("v_scki_edge1", v_scki, 1'b1);
        wait_edges(1);
        check("scki_edge2",   scki,   1'b1);
        check("v_scki_edge2", v_scki, 1'b0);
        wait_edges(1);
        check("v_bck_edge3", v_bck, 1'b0);
        wait_edges(1);
        check("v_bck_edge4", v_bck, 1'b1);
        wait_edges(3);
        check("bck_edge7", bck, 1'b0);
        wait_edges(1);
        check("bck_edge8", bck, 1'b1);
        wait_edges(119);
        check("v_lrck_edge127", v_lrck, 1'b0);
        wait_edges(1);
        check("v_lrck_edge128", v_lrck, 1'b1);
        wait_edges(383);
        check("lrck_edge511", lrck, LRCK_LEFT);
        wait_edges(1);
        check("lrck_edge512", lrck, LRCK_RIGHT);

        wait_edges(4096 - 512);
        counting = 0;
        check_int("edges_since_release", int'(n), 4096);
        check_int("scki_rises_4096", scki_rises, 1024);
        check_int("bck_rises_4096",  bck_rises,  256);
        check_int("lrck_rises_4096", lrck_rises, 4);
        check_int("v_lrck_rises_4096", v_lrck_rises, 16);

        mid_reset(300, LRCK_LEFT);
        mid_reset(700, LRCK_RIGHT);
        wait_edges(1100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
